// File: rtl/decode_pkg.sv
// Decode-side types shared with the execution units.
package decode_pkg;

    typedef logic [63:0] u64;

    typedef enum logic [2:0] {
        MULT_MUL,
        MULT_MULW,
        MULT_DIV,
        MULT_DIVU,
        MULT_REM,
        MULT_REMU
    } mult_type_t;

endpackage

// File: rtl/multdiv_unit.sv
// Iterative RV64 multiply/divide unit: restoring radix-2 divide plus shift-add multiply.
// Build option MULTDIV_FAST_MUL_EN swaps the shift-add multiply for a single-cycle array multiply.
module multdiv_unit
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  mult_type_t  mult_type,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    mult_type_t  op, op_next;
    logic [5:0]  count, count_next;
    logic [63:0] opa, opa_next;
    logic [63:0] opb, opb_next;
    logic [63:0] acc, acc_next;
    logic [63:0] result_next;
    logic        neg_q, neg_q_next;
    logic        neg_r, neg_r_next;

    logic        accept;
    logic        in_is_div, in_is_signed, in_special;
    logic [63:0] in_abs_a, in_abs_b, special_result;
    logic        op_is_div, op_is_rem, busy_last;
    logic [64:0] rem_shift, rem_trial;
    logic [63:0] div_quo, div_rem, div_final;
    logic [63:0] mul_product, mul_final;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;

    assign in_is_div    = mult_type inside {MULT_DIV, MULT_DIVU, MULT_REM, MULT_REMU};
    assign in_is_signed = mult_type inside {MULT_DIV, MULT_REM};
    assign in_abs_a     = (in_is_signed && src1[63]) ? -src1 : src1;
    assign in_abs_b     = (in_is_signed && src2[63]) ? -src2 : src2;

    // Divide-by-zero and signed overflow are answered at accept without iterating.
    always_comb begin
        in_special     = 1'b0;
        special_result = '0;
        if (src2 == '0) begin
            in_special     = in_is_div;
            special_result = (mult_type inside {MULT_REM, MULT_REMU}) ? src1 : '1;
        end else if (in_is_signed && src1 == 64'h8000_0000_0000_0000 && src2 == '1) begin
            in_special     = 1'b1;
            special_result = (mult_type == MULT_REM) ? '0 : src1;
        end
    end

    // acc holds the partial remainder and opa shifts dividend bits out while quotient bits shift in.
    assign op_is_div = op inside {MULT_DIV, MULT_DIVU, MULT_REM, MULT_REMU};
    assign op_is_rem = op inside {MULT_REM, MULT_REMU};
    assign rem_shift = {acc, opa[63]};
    assign rem_trial = rem_shift - {1'b0, opb};
    assign div_quo   = {opa[62:0], ~rem_trial[64]};
    assign div_rem   = rem_trial[64] ? rem_shift[63:0] : rem_trial[63:0];
    assign div_final = op_is_rem ? (neg_r ? -div_rem : div_rem)
                                 : (neg_q ? -div_quo : div_quo);

`ifdef MULTDIV_FAST_MUL_EN
    assign mul_product = opa * opb;
    assign busy_last   = !op_is_div || (count == '0);
`else
    assign mul_product = acc + (opa[0] ? opb : '0);
    assign busy_last   = (count == '0);
`endif
    assign mul_final = (op == MULT_MULW) ? {{32{mul_product[31]}}, mul_product[31:0]}
                                         : mul_product;

    always_comb begin
        state_next  = state;
        op_next     = op;
        count_next  = count;
        opa_next    = opa;
        opb_next    = opb;
        acc_next    = acc;
        neg_q_next  = neg_q;
        neg_r_next  = neg_r;
        result_next = result;
        case (state)
            IDLE: begin
                if (accept) begin
                    op_next    = mult_type;
                    count_next = 6'd63;
                    opa_next   = in_abs_a;
                    opb_next   = in_abs_b;
                    acc_next   = '0;
                    neg_q_next = in_is_signed & (src1[63] ^ src2[63]);
                    neg_r_next = in_is_signed & src1[63];
                    if (in_special) begin
                        state_next  = DONE;
                        result_next = special_result;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                count_next = count - 6'd1;
                if (op_is_div) begin
                    opa_next = div_quo;
                    acc_next = div_rem;
                end else begin
                    opa_next = opa >> 1;
                    opb_next = opb << 1;
                    acc_next = mul_product;
                end
                if (busy_last) begin
                    state_next  = DONE;
                    result_next = op_is_div ? div_final : mul_final;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // A kill must never publish a result, even on what would have been the last iteration.
        if (flush) begin
            state_next  = IDLE;
            result_next = result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= MULT_MUL;
            count  <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_next;
            op     <= op_next;
            count  <= count_next;
            opa    <= opa_next;
            opb    <= opb_next;
            acc    <= acc_next;
            neg_q  <= neg_q_next;
            neg_r  <= neg_r_next;
            result <= result_next;
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomised and directed bench for multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;
    import decode_pkg::*;

`ifdef MULTDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 64;
`endif
    localparam int TIMEOUT = 200;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    mult_type_t  mult_type;
    logic [63:0] src1, src2, result;
    int          check_count = 0;
    int          pass_count  = 0;

    multdiv_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mult_type(mult_type), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    // Reference result straight from the RISC-V arithmetic definitions.
    function automatic logic [63:0] model_result(input mult_type_t op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, sq;
        logic [31:0] w;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MINV) && (b == ONES);
        w   = a[31:0] * b[31:0];
        case (op)
            MULT_MUL:  return a * b;
            MULT_MULW: return {{32{w[31]}}, w};
            MULT_DIV: begin
                if (b == 0) return ONES;
                if (ovf) return a;
                sq = sa / sb;
                return sq;
            end
            MULT_REM: begin
                if (b == 0) return a;
                if (ovf) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            MULT_DIVU: return (b == 0) ? ONES : a / b;
            MULT_REMU: return (b == 0) ? a : a % b;
            default:   return 64'd0;
        endcase
    endfunction

    // Index of the edge (accept edge = 0) at which the result appears.
    function automatic int model_latency(input mult_type_t op, input logic [63:0] a, input logic [63:0] b);
        if (op == MULT_MUL || op == MULT_MULW) return MUL_LAT;
        if (b == 0) return 0;
        if ((op == MULT_DIV || op == MULT_REM) && a == MINV && b == ONES) return 0;
        return 64;
    endfunction

    // Issue one op from IDLE, wait for it, capture it, then consume it.
    task automatic do_op(input mult_type_t op, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] res);
        in_valid  = 1'b1;
        mult_type = op;
        src1      = a;
        src2      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        mult_type = MULT_MUL; src1 = '0; src2 = '0;
        #1;
        check_count++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("[TB] FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
        else pass_count++;
        check_count++;
        if (result !== 64'd0) $display("[TB] FAIL reset_result: got %h expected 0", result);
        else pass_count++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_count++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("[TB] FAIL post_reset_handshake: got %b expected 10", {in_ready, out_valid});
        else pass_count++;
    endtask

    task automatic test_directed();
        mult_type_t  ops[8]  = '{MULT_DIV, MULT_REM, MULT_DIVU, MULT_REMU, MULT_DIV, MULT_REM, MULT_MULW, MULT_MUL};
        logic [63:0] as[8]   = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'd100, 64'd100,
                                 MINV, MINV, 64'h0000_0000_7FFF_FFFF, 64'h1_0000_0000};
        logic [63:0] bs[8]   = '{64'd2, 64'd2, 64'd0, 64'd0, ONES, ONES, 64'd2, 64'h1_0000_0000};
        logic [63:0] exps[8] = '{64'hFFFF_FFFF_FFFF_FFFD, ONES, ONES, 64'd100, MINV, 64'd0,
                                 64'hFFFF_FFFF_FFFF_FFFE, 64'd0};
        int          lats[8] = '{64, 64, 0, 0, 0, 0, MUL_LAT, MUL_LAT};
        int lat;
        logic [63:0] res;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res);
            check_count++;
            if (res !== exps[i]) $display("[TB] FAIL directed[%0d]_result: got %h expected %h", i, res, exps[i]);
            else pass_count++;
            check_count++;
            if (lat != lats[i]) $display("[TB] FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, lats[i]);
            else pass_count++;
        end
    endtask

    task automatic test_hold();
        int lat;
        in_valid = 1'b1; mult_type = MULT_DIVU; src1 = 64'd50; src2 = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
        check_count++;
        if (lat != 64) $display("[TB] FAIL hold_latency: got %0d expected 64", lat);
        else pass_count++;
        for (int i = 0; i < 10; i++) begin
            check_count++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 64'd7})
                $display("[TB] FAIL hold_cycle[%0d]: got v=%b r=%b res=%h expected v=1 r=0 res=7", i, out_valid, in_ready, result);
            else pass_count++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_count++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("[TB] FAIL hold_release: got %b expected 10", {in_ready, out_valid});
        else pass_count++;
    endtask

    task automatic test_flush();
        logic seen;
        int lat;
        logic [63:0] res;
        in_valid = 1'b1; mult_type = MULT_DIV; src1 = 64'd1000; src2 = 64'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (29) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_count++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("[TB] FAIL flush_busy: got %b expected 10", {in_ready, out_valid});
        else pass_count++;
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= out_valid; end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL flush_busy_no_result: got %b expected 0", seen);
        else pass_count++;

        in_valid = 1'b1; flush = 1'b1; mult_type = MULT_DIVU; src1 = 64'd5; src2 = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = ~in_ready | out_valid;
        repeat (70) begin @(posedge clk); #1; seen |= ~in_ready | out_valid; end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL flush_accept: got %b expected 0", seen);
        else pass_count++;

        in_valid = 1'b1; mult_type = MULT_DIVU; src1 = 64'd9; src2 = 64'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_count++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("[TB] FAIL flush_done: got %b expected 10", {in_ready, out_valid});
        else pass_count++;

        do_op(MULT_DIVU, 64'd100, 64'd7, lat, res);
        check_count++;
        if (res !== 64'd14) $display("[TB] FAIL after_flush_result: got %h expected e", res);
        else pass_count++;
    endtask

    task automatic test_async_reset();
        logic seen;
        in_valid = 1'b1; mult_type = MULT_DIV; src1 = 64'hFFFF_FFFF_FFFF_FF9C; src2 = 64'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check_count++;
        if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 64'd0})
            $display("[TB] FAIL async_reset: got r=%b v=%b res=%h expected r=1 v=0 res=0", in_ready, out_valid, result);
        else pass_count++;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= out_valid; end
        check_count++;
        if (seen !== 1'b0) $display("[TB] FAIL async_reset_no_result: got %b expected 0", seen);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; mult_type = MULT_DIVU; src1 = 64'd100; src2 = 64'd0;
        @(posedge clk); #1;
        mult_type = MULT_REMU; src1 = 64'd6;
        check_count++;
        if ({out_valid, in_ready} !== 2'b10)
            $display("[TB] FAIL b2b_done_blocks: got %b expected 10", {out_valid, in_ready});
        else pass_count++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_count++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("[TB] FAIL b2b_no_same_cycle: got %b expected 01", {out_valid, in_ready});
        else pass_count++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_count++;
        if ({out_valid, result} !== {1'b1, 64'd6})
            $display("[TB] FAIL b2b_second: got v=%b res=%h expected v=1 res=6", out_valid, result);
        else pass_count++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        mult_type_t op;
        logic [63:0] a, b, exp_res, res;
        int lat, exp_lat, sel;
        for (int i = 0; i < 24; i++) begin
            op  = mult_type_t'($urandom_range(0, 5));
            sel = $urandom_range(0, 7);
            a   = {$urandom, $urandom};
            b   = {$urandom, $urandom};
            if (sel == 0) b = 64'd0;
            else if (sel == 1) begin a = MINV; b = ONES; end
            else if (sel == 2) begin
                a = 64'($urandom_range(0, 1000));
                b = 64'($urandom_range(1, 50));
                if ($urandom_range(0, 1) == 1) a = -a;
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            exp_res = model_result(op, a, b);
            exp_lat = model_latency(op, a, b);
            do_op(op, a, b, lat, res);
            check_count++;
            if (res !== exp_res)
                $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, exp_res);
            else pass_count++;
            check_count++;
            if (lat != exp_lat)
                $display("[TB] FAIL random[%0d]_latency op=%0d: got %0d expected %0d", i, op, lat, exp_lat);
            else pass_count++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
